psx_pad_host: RTL and testbench
===============================

# psx_pad_host

Console-side master for the PSX controller port: on request it selects the pad, clocks out a 5-byte poll (0x01, 0x42, 0x00, 0x00, 0x00), samples the pad's reply, honours the per-byte ack handshake and presents the 16 button bits. It is the counterpart of the fake controller: on-chip, in the same design, it drives `psx_clk`, `att` and `cmd` into the pad model or a real pad, and feeds `buttons` to the game logic.

## Interface
- `CLK_DIV`, 4: `clk` cycles per `psx_clk` half-period; legal range ≥2.
- `ATT_DELAY`, 8: `clk` cycles from `att` falling to the first `psx_clk` fall.
- `ACK_TIMEOUT`, 64: maximum `clk` cycles to wait for ack after bytes 0–3.
- `clk` in 1: system clock; all state on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle poll request.
- `data` in 1: pad-to-console serial data, LSB first.
- `ack` in 1: pad acknowledge, active-low pulse, asynchronous.
- `psx_clk` out 1: serial clock, idles high.
- `att` out 1: pad select, active-low, idles high.
- `cmd` out 1: console-to-pad serial data, LSB first, idles high.
- `buttons` out 16: {byte4, byte3} as received, active-low raw; holds its value between polls.
- `valid` out 1: one-cycle pulse when `buttons` is updated.
- `error` out 1: one-cycle pulse on a failed poll.
- `busy` out 1: high from the cycle after accepted `start` until return to IDLE.

## Operation
- States: IDLE → SETUP → SHIFT → ACKWAIT → (SHIFT | FINISH) → IDLE.
- IDLE: `att`=`psx_clk`=`cmd`=1. `start`=1 is accepted; `start` is ignored in every other state.
- SETUP: `att`=0 and count `ATT_DELAY` cycles, then enter SHIFT with byte index 0.
- SHIFT: 8 bits per byte. For each bit, `psx_clk` falls and `cmd` takes the next LSB-first bit on the same cycle. After `CLK_DIV` cycles `psx_clk` rises and `data` is shifted into the receive register on that cycle. After a further `CLK_DIV` cycles the next bit starts.
- After bit 7 of bytes 0–3, enter ACKWAIT. After bit 7 of byte 4, enter FINISH.
- ACKWAIT: `psx_clk`=1 and `cmd`=1.
  - `ack` passes through a 2-flop synchronizer. A synchronized low level at any time in the window counts as ack; a minimum low width of 2 `clk` cycles is guaranteed.
  - On ack: wait `CLK_DIV` cycles, then go to SHIFT for the next byte.
  - If no ack within `ACK_TIMEOUT` cycles: pulse `error`, set `att`=1, go to IDLE, leave `buttons` unchanged.
  - An ack that is already low on ACKWAIT entry counts.
- Received byte 1 is the ID and must equal 0x41; byte 2 must equal 0x5A (see Configuration). Byte 0 is ignored.
- FINISH: hold `psx_clk`=1 for `CLK_DIV` cycles. Then, on the same cycle: `att`=1, `buttons` ← {byte4, byte3}, `valid`=1, and the next state is IDLE.
- Reset (any time, including mid-transfer): IDLE, `att`=1, `psx_clk`=1, `cmd`=1, `buttons`=16'hFFFF, `valid`=0, `error`=0, `busy`=0, all counters 0.

## Timing
- `start` accepted at cycle T: `att`=0 and `busy`=1 from T+1.
- First `psx_clk` fall at T+1+`ATT_DELAY`.
- One byte = 16·`CLK_DIV` cycles.
- Poll with immediate acks, sync delay s=2: 1 + `ATT_DELAY` + 5·16·`CLK_DIV` + 4·(s+`CLK_DIV`) + `CLK_DIV` cycles to the `valid` pulse.
- `valid` and `error` are never high together and never repeat without a new `start`.
- `busy` falls the cycle after `valid` or `error`. A `start` on that same cycle is accepted.

## Configuration
- `PSX_HOST_ID_CHECK_EN` defined: a mismatch on byte 1 (≠0x41) or byte 2 (≠0x5A) still completes the transfer. FINISH then pulses `error` instead of `valid`, and `buttons` keeps its previous value.
- `PSX_HOST_ID_CHECK_EN` undefined: ID bytes are not checked, and every completed transfer pulses `valid`.

## Test plan
- Pad model replying FF 41 5A 7F FF, acks 3 cycles after each of bytes 0–3 → `cmd` bytes observed 01 42 00 00 00; `buttons`=16'hFF7F; one `valid` pulse at the cycle count given in Timing.
- Pad never acks → `error` pulses at exactly `ACK_TIMEOUT` cycles after byte 0 ends; `att` returns to 1; exactly 8 `psx_clk` falls occurred; `buttons` unchanged.
- Ack already low when ACKWAIT is entered; also a 2-cycle ack pulse arriving at cycle `ACK_TIMEOUT`−3 → both accepted, poll completes.
- `rst_n` low in the middle of byte 2 → outputs take reset values immediately (async); a following `start` runs a clean full poll.
- `start` pulsed every cycle during a poll → only one transaction; a `start` on the cycle `busy` falls begins the next poll.
- With `PSX_HOST_ID_CHECK_EN` defined and the pad replying ID 0x73 → `error`=1, `valid`=0, `buttons` stays 16'hFFFF. Without the macro → `valid`=1.

Source files
------------

// File: rtl/psx_pad_host_if.sv
// Host-side bundle for the PSX pad port: request/status toward game logic, serial lines toward the pad.
// Latency: none (wires only).
// Backpressure: none; master is the console-side host, slave is the pad/requester side.
interface psx_pad_host_if;
   logic        start;
   logic        data;
   logic        ack;
   logic        psx_clk;
   logic        att;
   logic        cmd;
   logic [15:0] buttons;
   logic        valid;
   logic        error;
   logic        busy;

   modport master (
      input  start, data, ack,
      output psx_clk, att, cmd, buttons, valid, error, busy
   );

   modport slave (
      output start, data, ack,
      input  psx_clk, att, cmd, buttons, valid, error, busy
   );
endinterface

// File: rtl/psx_pad_host.sv
// PSX pad poll master: sends 01 42 00 00 00, returns {byte4, byte3}; PSX_HOST_ID_CHECK_EN rejects bad ID bytes.
// Latency: 1 + ATT_DELAY + 80*CLK_DIV + per-byte ack waits + CLK_DIV cycles from start to valid/error.
// Backpressure: none; start is ignored while busy, ack timeout aborts the poll.
module psx_pad_host #(
   parameter int CLK_DIV     = 4,
   parameter int ATT_DELAY   = 8,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   psx_pad_host_if.master bus
);
   localparam int MAX_AC = (ACK_TIMEOUT > ATT_DELAY) ? ACK_TIMEOUT : ATT_DELAY;
   localparam int MAXV   = (MAX_AC > CLK_DIV) ? MAX_AC : CLK_DIV;
   localparam int CW     = $clog2(MAXV + 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, ACKWAIT, FINISH} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [2:0]    byte_idx, byte_nxt;
   logic          phase, phase_nxt;
   logic          acked, acked_nxt;
   logic [7:0]    rx_sh, rx_nxt;
   logic [7:0]    byte3, byte4;
   logic [7:0]    tx_byte;
   logic [15:0]   buttons_q;
   logic          ack_s1, ack_s2;
   logic          byte_end, xfer_done, timeout, id_bad;

   assign byte_end  = (state == SHIFT) && phase && (cnt == CW'(CLK_DIV - 1)) && (bit_idx == 3'd7);
   assign xfer_done = (state == FINISH) && (cnt == CW'(CLK_DIV));
   assign timeout   = (state == ACKWAIT) && !acked && (cnt == CW'(ACK_TIMEOUT));

   always_comb begin
      case (byte_idx)
         3'd0:    tx_byte = 8'h01;
         3'd1:    tx_byte = 8'h42;
         default: tx_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      byte_nxt  = byte_idx;
      phase_nxt = phase;
      acked_nxt = acked;
      rx_nxt    = rx_sh;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = SETUP;
               cnt_nxt   = '0;
            end
         end
         SETUP: begin
            if (cnt == CW'(ATT_DELAY - 1)) begin
               state_nxt = SHIFT;
               cnt_nxt   = '0;
               bit_nxt   = 3'd0;
               byte_nxt  = 3'd0;
               phase_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         SHIFT: begin
            if (cnt != CW'(CLK_DIV - 1)) begin
               cnt_nxt = cnt + CW'(1);
            end else begin
               cnt_nxt = '0;
               if (!phase) begin
                  // Rising psx_clk: the pad has held data stable since the fall.
                  phase_nxt = 1'b1;
                  rx_nxt    = {bus.data, rx_sh[7:1]};
               end else begin
                  phase_nxt = 1'b0;
                  bit_nxt   = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     acked_nxt = 1'b0;
                     state_nxt = (byte_idx == 3'd4) ? FINISH : ACKWAIT;
                  end
               end
            end
         end
         ACKWAIT: begin
            if (acked) begin
               if (cnt == CW'(CLK_DIV - 1)) begin
                  state_nxt = SHIFT;
                  cnt_nxt   = '0;
                  byte_nxt  = byte_idx + 3'd1;
                  phase_nxt = 1'b0;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end else if (timeout) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (!ack_s2) begin
               // The detection cycle is the first of the CLK_DIV gap cycles.
               acked_nxt = 1'b1;
               cnt_nxt   = CW'(1);
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         FINISH: begin
            if (xfer_done) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= 3'd0;
         byte_idx  <= 3'd0;
         phase     <= 1'b0;
         acked     <= 1'b0;
         rx_sh     <= 8'h00;
         byte3     <= 8'hFF;
         byte4     <= 8'hFF;
         buttons_q <= 16'hFFFF;
         ack_s1    <= 1'b1;
         ack_s2    <= 1'b1;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_idx  <= bit_nxt;
         byte_idx <= byte_nxt;
         phase    <= phase_nxt;
         acked    <= acked_nxt;
         rx_sh    <= rx_nxt;
         ack_s1   <= bus.ack;
         ack_s2   <= ack_s1;
         if (byte_end && (byte_idx == 3'd3)) byte3 <= rx_sh;
         if (byte_end && (byte_idx == 3'd4)) byte4 <= rx_sh;
         if (xfer_done && !id_bad) buttons_q <= {byte4, byte3};
      end
   end

`ifdef PSX_HOST_ID_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_bad <= 1'b0;
      end else if (state == IDLE) begin
         id_bad <= 1'b0;
      end else if (byte_end && (byte_idx == 3'd1) && (rx_sh != 8'h41)) begin
         id_bad <= 1'b1;
      end else if (byte_end && (byte_idx == 3'd2) && (rx_sh != 8'h5A)) begin
         id_bad <= 1'b1;
      end
   end
`else
   assign id_bad = 1'b0;
`endif

   assign bus.att     = (state == IDLE) || xfer_done || timeout;
   assign bus.psx_clk = (state != SHIFT) || phase;
   assign bus.cmd     = (state == SHIFT) ? tx_byte[bit_idx] : 1'b1;
   assign bus.busy    = (state != IDLE);
   assign bus.valid   = xfer_done && !id_bad;
   assign bus.error   = timeout || (xfer_done && id_bad);
   assign bus.buttons = buttons_q;
endmodule

// File: tb/tb_psx_pad_host.sv
// Bench for psx_pad_host: behavioural pad model, poll timing from arithmetic, directed random polls.
module tb_psx_pad_host;
   localparam int C  = 4;
   localparam int AD = 8;
   localparam int A  = 64;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   psx_pad_host_if bus ();

   psx_pad_host #(.CLK_DIV(C), .ATT_DELAY(AD), .ACK_TIMEOUT(A)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Pad model configuration
   logic [7:0] reply [5];
   int         ack_d [4];
   int         ack_w [4];
   bit         ack_en;
   logic [7:0] exp_cmd [5] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};

   // Pad model state
   logic [7:0] cmd_q [$];
   logic [7:0] cmd_sh;
   int  pbit = 0, pbyte = 0, ack_wait = 0, ack_low = 0, falls = 0;
   logic prev_clk = 1'b1;

   always @(negedge clk) begin
      if (bus.att !== 1'b0) begin
         pbit = 0; pbyte = 0; ack_wait = 0; ack_low = 0;
         bus.ack = 1'b1; bus.data = 1'b1;
      end else begin
         if (ack_low > 0) begin
            ack_low--;
            if (ack_low == 0) bus.ack = 1'b1;
         end else if (ack_wait > 0) begin
            ack_wait--;
            if (ack_wait == 0) begin
               bus.ack = 1'b0;
               ack_low = ack_w[pbyte - 1];
            end
         end
         if (prev_clk && !bus.psx_clk) begin
            falls++;
            if (pbyte < 5) bus.data = reply[pbyte][pbit];
         end
         if (!prev_clk && bus.psx_clk) begin
            cmd_sh = {bus.cmd, cmd_sh[7:1]};
            pbit++;
            if (pbit == 8) begin
               cmd_q.push_back(cmd_sh);
               if (pbyte < 4 && ack_en) ack_wait = C + ack_d[pbyte];
               pbit = 0;
               pbyte++;
            end
         end
      end
      prev_clk = bus.psx_clk;
   end

   int n_valid = 0, n_error = 0, valid_cyc = -1, error_cyc = -1;
   always @(negedge clk) begin
      if (bus.valid === 1'b1) begin n_valid++; valid_cyc = cyc; end
      if (bus.error === 1'b1) begin n_error++; error_cyc = cyc; end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Ack seen by the host k cycles into the ack window when the pad drops ack d cycles after entry.
   function automatic int ackk(input int d);
      return (d + 2 > 0) ? d + 2 : 0;
   endfunction

   function automatic int poll_len();
      int n;
      n = 1 + AD + 5 * 16 * C + C;
      for (int i = 0; i < 4; i++) n += ackk(ack_d[i]) + C;
      return n;
   endfunction

   task automatic set_pad(input logic [7:0] id, input logic [7:0] b3, input logic [7:0] b4);
      reply[0] = 8'hFF; reply[1] = id; reply[2] = 8'h5A; reply[3] = b3; reply[4] = b4;
   endtask

   task automatic set_acks(input int d0, input int d1, input int d2, input int d3, input int w);
      ack_d[0] = d0; ack_d[1] = d1; ack_d[2] = d2; ack_d[3] = d3;
      for (int i = 0; i < 4; i++) ack_w[i] = w;
      ack_en = 1'b1;
   endtask

   task automatic wait_ev(input int v0, input int e0);
      for (int i = 0; i < 4000 && n_valid == v0 && n_error == e0; i++) begin
         @(negedge clk); #1;
      end
   endtask

   int pv0, pe0;
   task automatic do_poll(output int t0, output int ev, output bit gv, output bit ge);
      pv0 = n_valid; pe0 = n_error; t0 = cyc;
      bus.start = 1'b1;
      @(negedge clk); #1;
      bus.start = 1'b0;
      wait_ev(pv0, pe0);
      gv = (n_valid != pv0);
      ge = (n_error != pe0);
      ev = gv ? valid_cyc : (ge ? error_cyc : -1);
   endtask

   logic [15:0] exp_btn;

   task automatic post_poll(input string tag, input int dv, input int de);
      repeat (3) begin @(negedge clk); #1; end
      chk({tag, "_nvalid"}, 32'(n_valid - pv0), 32'(dv));
      chk({tag, "_nerror"}, 32'(n_error - pe0), 32'(de));
      chk({tag, "_att"}, 32'(bus.att), 32'd1);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_buttons"}, 32'(bus.buttons), 32'(exp_btn));
   endtask

   task automatic check_cmds(input string tag, input int q0);
      chk({tag, "_ncmd"}, 32'(cmd_q.size() - q0), 32'd5);
      for (int i = 0; i < 5; i++)
         chk({tag, "_cmd"}, (q0 + i < cmd_q.size()) ? 32'(cmd_q[q0 + i]) : 32'hDEAD, 32'(exp_cmd[i]));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_att"}, 32'(bus.att), 32'd1);
      chk({tag, "_psx_clk"}, 32'(bus.psx_clk), 32'd1);
      chk({tag, "_cmd"}, 32'(bus.cmd), 32'd1);
      chk({tag, "_buttons"}, 32'(bus.buttons), 32'hFFFF);
      chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
      chk({tag, "_error"}, 32'(bus.error), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, ev, q0, f0, v0, e0;
      bit gv, ge;
      logic [7:0] b3, b4;

      rst_n = 1'b1;
      bus.start = 1'b0;
      set_pad(8'h41, 8'h7F, 8'hFF);
      set_acks(3, 3, 3, 3, 2);
      #1 rst_n = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      exp_btn = 16'hFFFF;
      @(negedge clk); #1;

      // Reference pad reply, acks 3 cycles after each byte
      q0 = cmd_q.size();
      do_poll(t0, ev, gv, ge);
      chk("a_valid", 32'(gv), 32'd1);
      chk("a_time", 32'(ev - t0), 32'(poll_len()));
      check_cmds("a", q0);
      exp_btn = 16'hFF7F;
      post_poll("a", 1, 0);

      // Immediate acks: closed-form poll length
      b3 = 8'($urandom_range(0, 255)); b4 = 8'($urandom_range(0, 255));
      set_pad(8'h41, b3, b4);
      set_acks(0, 0, 0, 0, 2);
      do_poll(t0, ev, gv, ge);
      chk("b_valid", 32'(gv), 32'd1);
      chk("b_time", 32'(ev - t0), 32'(1 + AD + 5 * 16 * C + 4 * (2 + C) + C));
      exp_btn = {b4, b3};
      post_poll("b", 1, 0);

      // Pad never acks
      set_pad(8'h41, 8'h12, 8'h34);
      ack_en = 1'b0;
      f0 = falls;
      do_poll(t0, ev, gv, ge);
      chk("c_error", 32'(ge), 32'd1);
      chk("c_time", 32'(ev - t0), 32'(1 + AD + 16 * C + A));
      chk("c_falls", 32'(falls - f0), 32'd8);
      post_poll("c", 0, 1);

      // Ack already low at window entry, and a late 2-cycle pulse just inside the window
      b3 = 8'($urandom_range(0, 255)); b4 = 8'($urandom_range(0, 255));
      set_pad(8'h41, b3, b4);
      set_acks(-3, A - 3, -3, 0, 4);
      ack_w[1] = 2; ack_w[3] = 2;
      do_poll(t0, ev, gv, ge);
      chk("d_valid", 32'(gv), 32'd1);
      chk("d_time", 32'(ev - t0), 32'(poll_len()));
      exp_btn = {b4, b3};
      post_poll("d", 1, 0);

      // 2-cycle pulse one cycle too late: still a timeout
      set_pad(8'h41, 8'h55, 8'hAA);
      set_acks(A - 2, 0, 0, 0, 2);
      do_poll(t0, ev, gv, ge);
      chk("e_error", 32'(ge), 32'd1);
      chk("e_time", 32'(ev - t0), 32'(1 + AD + 16 * C + A));
      post_poll("e", 0, 1);

      // Asynchronous reset in the middle of byte 2
      set_pad(8'h41, 8'h00, 8'h00);
      set_acks(0, 0, 0, 0, 2);
      q0 = cmd_q.size();
      bus.start = 1'b1;
      @(negedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 2000 && cmd_q.size() < q0 + 2; i++) begin @(negedge clk); #1; end
      chk("f_reached_byte2", 32'(cmd_q.size() - q0), 32'd2);
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("f_midreset");
      exp_btn = 16'hFFFF;
      @(negedge clk); #1 rst_n = 1'b1;
      @(negedge clk); #1;

      // Bad ID byte (0x73)
      set_pad(8'h73, 8'h3C, 8'hC3);
      set_acks(1, 0, 2, 0, 2);
      do_poll(t0, ev, gv, ge);
`ifdef PSX_HOST_ID_CHECK_EN
      chk("h_error", 32'(ge), 32'd1);
      chk("h_valid", 32'(gv), 32'd0);
      chk("h_time", 32'(ev - t0), 32'(poll_len()));
      post_poll("h", 0, 1);
`else
      chk("h_valid", 32'(gv), 32'd1);
      chk("h_time", 32'(ev - t0), 32'(poll_len()));
      exp_btn = 16'hC33C;
      post_poll("h", 1, 0);
`endif

      // Clean full poll after the reset
      b3 = 8'($urandom_range(0, 255)); b4 = 8'($urandom_range(0, 255));
      set_pad(8'h41, b3, b4);
      set_acks(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 2);
      q0 = cmd_q.size();
      do_poll(t0, ev, gv, ge);
      chk("g_valid", 32'(gv), 32'd1);
      chk("g_time", 32'(ev - t0), 32'(poll_len()));
      check_cmds("g", q0);
      exp_btn = {b4, b3};
      post_poll("g", 1, 0);

      // start held high through a poll, then on the cycle busy falls
      b3 = 8'($urandom_range(0, 255)); b4 = 8'($urandom_range(0, 255));
      set_pad(8'h41, b3, b4);
      set_acks(0, 1, 2, 3, 2);
      v0 = n_valid; e0 = n_error; t0 = cyc;
      bus.start = 1'b1;
      wait_ev(v0, e0);
      chk("s_time", 32'(valid_cyc - t0), 32'(poll_len()));
      chk("s_one", 32'(n_valid - v0), 32'd1);
      @(negedge clk); #1;
      chk("s_busy_low", 32'(bus.busy), 32'd0);
      t1 = cyc;
      @(negedge clk); #1;
      bus.start = 1'b0;
      chk("s_busy_restart", 32'(bus.busy), 32'd1);
      chk("s_still_one", 32'(n_valid - v0), 32'd1);
      exp_btn = {b4, b3};
      b3 = 8'($urandom_range(0, 255)); b4 = 8'($urandom_range(0, 255));
      reply[3] = b3; reply[4] = b4;
      v0 = n_valid;
      wait_ev(v0, e0);
      chk("s2_valid", 32'(n_valid - v0), 32'd1);
      chk("s2_time", 32'(valid_cyc - t1), 32'(poll_len()));
      chk("s2_noerr", 32'(n_error - e0), 32'd0);
      repeat (2) begin @(negedge clk); #1; end
      chk("s2_buttons", 32'(bus.buttons), 32'({b4, b3}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
